mtl2_cpu_ocimem_arbiter: RTL and testbench
==========================================

Name: mtl2_cpu_ocimem_arbiter

Overview:
Sequences and arbitrates access to the CPU's on-chip debug (OCI) memory between two requesters: JTAG debug commands and the Avalon debug slave. JTAG commands arrive as one-cycle take_* pulses plus jdo, already synchronised to clk. Avalon accesses use a waitrequest handshake. The block drives one single-port synchronous RAM with 1-cycle read latency, and returns JTAG read data on MonDReg with a monitor_ready flag.

Parameters:
ADDR_W, 8, OCI RAM word-address width (2^ADDR_W words).
DATA_W, 32, RAM data width; fixed at 32, since jdo carries 32 data bits.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
take_action_ocimem_a  in  1  pulse: load JTAG address from jdo[ADDR_W+16:17]
take_action_ocimem_b  in  1  pulse: JTAG write of jdo[34:3] at JTAG address, then auto-increment
take_no_action_ocimem_a  in  1  pulse: JTAG read at JTAG address, then auto-increment
jdo  in  38  JTAG data-out word
av_address  in  ADDR_W  Avalon word address
av_read  in  1  Avalon read request
av_write  in  1  Avalon write request
av_writedata  in  32  Avalon write data
av_byteenable  in  4  Avalon byte enables
av_readdata  out  32  Avalon read data
av_waitrequest  out  1  Avalon stall
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  32  RAM write data
ram_be  out  4  RAM byte enables
ram_we  out  1  RAM write strobe
ram_rdata  in  32  RAM read data, valid the cycle after address
MonDReg  out  32  last JTAG read result
monitor_ready  out  1  JTAG read/write done, no op pending
jtag_overrun  out  1  sticky: JTAG pulse dropped

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on the port named reset.
- Reset values: state=IDLE, jtag_addr=0, jtag_pend=0, last_jtag=0, MonDReg=0, monitor_ready=1, jtag_overrun=0, ram_we=0, av_waitrequest=1, av_readdata=0.
- JTAG pulse on an rd/wr pulse when jtag_pend=0:
  - set jtag_pend and latch op/data; monitor_ready<=0.
  - Grant eligibility starts the next cycle.
- JTAG pulse on an rd/wr pulse when jtag_pend=1: pulse dropped, jtag_overrun<=1.
- Address load (take_action_ocimem_a):
  - jtag_pend=0: jtag_addr loaded, jtag_overrun cleared.
  - jtag_pend=1: ignored, jtag_overrun<=1.
  - Load and overrun-set in the same cycle: set wins.
- States:
  - IDLE: only state that issues grants.
  - JRD: one cycle, MonDReg<=ram_rdata.
  - ARD: one cycle, av_readdata=ram_rdata.
- Grant in IDLE:
  - Requests are jtag_pend and (av_read|av_write).
  - Both requesting: Avalon wins if last_jtag=1, else JTAG. A lone requester always wins.
  - last_jtag updates on every grant.
- JTAG write grant:
  - ram_we=1, ram_be=4'hF, ram_addr=jtag_addr.
  - Same cycle: jtag_pend<=0, monitor_ready<=1, jtag_addr<=jtag_addr+1.
- JTAG read grant:
  - ram_addr=jtag_addr, go to JRD.
  - In JRD: MonDReg updated, monitor_ready<=1, jtag_pend<=0, jtag_addr+1, return to IDLE.
  - Read latency, pulse to MonDReg valid: 3 cycles uncontended.
- Address increment wraps at 2^ADDR_W-1 -> 0.
- Avalon write grant: ram_we=1, ram_be=av_byteenable, av_waitrequest=0 in the same cycle.
- Avalon read grant:
  - Address issued, go to ARD. av_waitrequest=0 only in ARD, with av_readdata valid; return to IDLE.
  - av_waitrequest is combinational, =1 otherwise.
- Master rules: holds request and address stable while av_waitrequest=1. av_read and av_write both high = protocol violation, serviced as write.
- No grant in JRD/ARD: reads occupy 2 cycles, writes 1.
- Reset mid-read: the read is discarded; no waitrequest drop, no MonDReg update.

Decomposition:
- Package mtl2_cpu_ocimem_pkg holds:
  - state encoding (IDLE/JRD/ARD);
  - jdo field constants: JDO_ADDR_LSB=17, JDO_WDATA_LSB=3, JDO_WDATA_MSB=34.
- One sub-module, mtl2_cpu_ocimem_rr_arb: 2-requester round-robin with the last_jtag register, grant_jtag/grant_av outputs, and an enable input (IDLE only).

Test Plan:
- Reset then JTAG write sequence:
  - Stimulus: load addr 0x10; write 0xDEADBEEF, then write 0x12345678.
  - Response: RAM[0x10]=0xDEADBEEF, RAM[0x11]=0x12345678, jtag_addr=0x12, monitor_ready back to 1 each time.
- JTAG read:
  - Stimulus: preload RAM[0x20]=0xA5A5A5A5; load addr 0x20; read pulse.
  - Response: monitor_ready=0, then 3 cycles later MonDReg=0xA5A5A5A5 and monitor_ready=1.
- Contention:
  - Stimulus: Avalon read of 0x05 held continuously while JTAG read pulses repeat.
  - Response: grants alternate JTAG, Avalon, JTAG; av_waitrequest drops only in ARD cycles; no starvation.
- Overrun:
  - Stimulus: a second write pulse while the first is still pending due to Avalon traffic.
  - Response: jtag_overrun=1, second write absent from RAM.
  - Then a take_action_ocimem_a pulse: jtag_overrun clears.
- Wrap: load addr 0xFF, write twice -> RAM[0xFF] and RAM[0x00] written.
- Mid-operation reset and byte enables:
  - Reset asserted the cycle after an Avalon read grant -> av_waitrequest stays 1, state returns to IDLE.
  - Avalon write with be=4'b0010 -> only byte 1 changes.

Source files
------------

// File: rtl/mtl2_cpu_ocimem_pkg.sv
// mtl2_cpu_ocimem_pkg: shared state encoding and jdo field positions for the OCI memory arbiter.
package mtl2_cpu_ocimem_pkg;
   typedef enum logic [1:0] {IDLE, JRD, ARD} state_t;
   localparam int JDO_ADDR_LSB  = 17;
   localparam int JDO_WDATA_LSB = 3;
   localparam int JDO_WDATA_MSB = 34;
endpackage

// File: rtl/mtl2_cpu_ocimem_rr_arb.sv
// mtl2_cpu_ocimem_rr_arb: two-requester round-robin between JTAG and Avalon, remembering the last winner.
module mtl2_cpu_ocimem_rr_arb (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic req_jtag,
   input  logic req_av,
   output logic grant_jtag,
   output logic grant_av
);
   logic last_jtag;
   always_comb begin
      grant_jtag = en && req_jtag && (!req_av || !last_jtag);
      grant_av   = en && req_av && (!req_jtag || last_jtag);
   end
   always_ff @(posedge clk) begin
      if (reset)
         last_jtag <= 1'b0;
      else if (grant_jtag || grant_av)
         last_jtag <= grant_jtag;
   end
endmodule

// File: rtl/mtl2_cpu_ocimem_arbiter.sv
// mtl2_cpu_ocimem_arbiter: sequences JTAG debug commands and Avalon debug-slave accesses onto one OCI RAM port.
module mtl2_cpu_ocimem_arbiter
   import mtl2_cpu_ocimem_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   input  logic [37:0]       jdo,
   input  logic [ADDR_W-1:0] av_address,
   input  logic              av_read,
   input  logic              av_write,
   input  logic [DATA_W-1:0] av_writedata,
   input  logic [3:0]        av_byteenable,
   output logic [DATA_W-1:0] av_readdata,
   output logic              av_waitrequest,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic [3:0]        ram_be,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [DATA_W-1:0] MonDReg,
   output logic              monitor_ready,
   output logic              jtag_overrun
);
   state_t state, state_nxt;
   logic [ADDR_W-1:0] jtag_addr;
   logic [DATA_W-1:0] jtag_wdata;
   logic jtag_pend, jtag_wr, jtag_pulse, grant_jtag, grant_av, ard_live;
   logic unused_jdo;
   assign unused_jdo = ^{jdo[37:35], jdo[2:0]};
   assign jtag_pulse = take_action_ocimem_b || take_no_action_ocimem_a;
   // Reset masks the read-return cycle so an interrupted read never completes.
   assign ard_live = (state == ARD) && !reset;
   mtl2_cpu_ocimem_rr_arb u_arb (
      .clk        (clk),
      .reset      (reset),
      .en         ((state == IDLE) && !reset),
      .req_jtag   (jtag_pend),
      .req_av     (av_read || av_write),
      .grant_jtag (grant_jtag),
      .grant_av   (grant_av)
   );
   always_comb begin
      ram_addr       = grant_jtag ? jtag_addr : av_address;
      ram_wdata      = grant_jtag ? jtag_wdata : av_writedata;
      ram_be         = grant_jtag ? 4'hF : av_byteenable;
      ram_we         = grant_jtag ? jtag_wr : (grant_av && av_write);
      av_waitrequest = !((grant_av && av_write) || ard_live);
      av_readdata    = ard_live ? ram_rdata : '0;
      state_nxt      = (state != IDLE) ? IDLE :
                       (grant_jtag && !jtag_wr) ? JRD :
                       (grant_av && !av_write) ? ARD : IDLE;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         jtag_addr     <= '0;
         jtag_pend     <= 1'b0;
         jtag_wr       <= 1'b0;
         jtag_wdata    <= '0;
         MonDReg       <= '0;
         monitor_ready <= 1'b1;
         jtag_overrun  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (jtag_pend && (jtag_pulse || take_action_ocimem_a))
            jtag_overrun <= 1'b1;
         else if (take_action_ocimem_a) begin
            jtag_overrun <= 1'b0;
            jtag_addr    <= jdo[JDO_ADDR_LSB+ADDR_W-1:JDO_ADDR_LSB];
         end
         if (!jtag_pend && jtag_pulse) begin
            jtag_pend     <= 1'b1;
            jtag_wr       <= take_action_ocimem_b;
            jtag_wdata    <= jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
            monitor_ready <= 1'b0;
         end
         if ((grant_jtag && jtag_wr) || state == JRD) begin
            jtag_pend     <= 1'b0;
            monitor_ready <= 1'b1;
            jtag_addr     <= jtag_addr + 1'b1;
         end
         if (state == JRD)
            MonDReg <= ram_rdata;
      end
   end
endmodule

// File: tb/tb_mtl2_cpu_ocimem_arbiter.sv
// tb_mtl2_cpu_ocimem_arbiter: directed stimulus with a transaction-level model of the JTAG and Avalon paths.
module tb_mtl2_cpu_ocimem_arbiter;
   import mtl2_cpu_ocimem_pkg::*;
   logic clk = 1'b0, reset = 1'b1;
   logic take_action_ocimem_a = 1'b0, take_action_ocimem_b = 1'b0, take_no_action_ocimem_a = 1'b0;
   logic [37:0] jdo = '0;
   logic [7:0] av_address = '0;
   logic av_read = 1'b0, av_write = 1'b0;
   logic [31:0] av_writedata = '0;
   logic [3:0] av_byteenable = '0;
   logic [31:0] av_readdata, ram_wdata, MonDReg;
   logic [31:0] ram_rdata = '0;
   logic av_waitrequest, ram_we, monitor_ready, jtag_overrun;
   logic [7:0] ram_addr;
   logic [3:0] ram_be;
   logic [31:0] ram [256] = '{default: '0};
   logic [31:0] exp_mem [256] = '{default: '0};
   int n_chk = 0, n_fail = 0;
   logic m_busy = 1'b0, m_wr = 1'b0, m_ovr = 1'b0, jdone = 1'b0;
   logic [7:0] m_addr = '0;
   logic [31:0] m_wdata = '0;
   string glog = "";

   mtl2_cpu_ocimem_arbiter dut (
      .clk                     (clk),
      .reset                   (reset),
      .take_action_ocimem_a    (take_action_ocimem_a),
      .take_action_ocimem_b    (take_action_ocimem_b),
      .take_no_action_ocimem_a (take_no_action_ocimem_a),
      .jdo                     (jdo),
      .av_address              (av_address),
      .av_read                 (av_read),
      .av_write                (av_write),
      .av_writedata            (av_writedata),
      .av_byteenable           (av_byteenable),
      .av_readdata             (av_readdata),
      .av_waitrequest          (av_waitrequest),
      .ram_addr                (ram_addr),
      .ram_wdata               (ram_wdata),
      .ram_be                  (ram_be),
      .ram_we                  (ram_we),
      .ram_rdata               (ram_rdata),
      .MonDReg                 (MonDReg),
      .monitor_ready           (monitor_ready),
      .jtag_overrun            (jtag_overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (ram_we && ram_be[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= ram[ram_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model: stimulus is absorbed on rising edges, DUT outputs are judged on falling edges.
   always @(posedge clk or negedge clk) begin
      if (clk) begin
         if (reset) begin
            m_busy = 1'b0;
            m_ovr  = 1'b0;
            m_addr = '0;
         end else if (m_busy) begin
            if (take_action_ocimem_a || take_action_ocimem_b || take_no_action_ocimem_a) m_ovr = 1'b1;
         end else begin
            if (take_action_ocimem_a) begin
               m_addr = jdo[24:17];
               m_ovr  = 1'b0;
            end
            if (take_action_ocimem_b || take_no_action_ocimem_a) begin
               m_busy  = 1'b1;
               m_wr    = take_action_ocimem_b;
               m_wdata = jdo[34:3];
            end
         end
      end else if (!reset) begin
         chk("overrun", jtag_overrun, m_ovr);
         if (monitor_ready && m_busy) begin
            if (m_wr) begin
               exp_mem[m_addr] = m_wdata;
               chk("jtag_write", ram[m_addr], m_wdata);
            end else
               chk("jtag_read", MonDReg, exp_mem[m_addr]);
            glog   = {glog, "J"};
            m_addr = m_addr + 8'd1;
            m_busy = 1'b0;
         end else
            chk("monitor_ready", monitor_ready, !m_busy);
         if (!av_waitrequest) begin
            if (av_write) begin
               for (int b = 0; b < 4; b++)
                  if (av_byteenable[b]) exp_mem[av_address][8*b +: 8] = av_writedata[8*b +: 8];
            end else if (av_read) begin
               chk("av_read", av_readdata, exp_mem[av_address]);
               glog = {glog, "A"};
            end else
               chk("waitreq_idle", 32'(av_waitrequest), 32'd1);
         end
      end
   end

   task automatic jtag(input int kind, input logic [31:0] v);
      @(posedge clk); #1;
      jdo = (kind == 0) ? {13'b0, v[7:0], 17'b0} : {3'b0, v, 3'b0};
      take_action_ocimem_a    = (kind == 0);
      take_action_ocimem_b    = (kind == 1);
      take_no_action_ocimem_a = (kind == 2);
      @(posedge clk); #1;
      take_action_ocimem_a    = 1'b0;
      take_action_ocimem_b    = 1'b0;
      take_no_action_ocimem_a = 1'b0;
   endtask

   task automatic wait_idle;
      for (int n = 0; n < 40 && m_busy; n++) begin
         @(negedge clk); #1;
      end
      if (m_busy) chk("jtag_timeout", 32'd1, 32'd0);
   endtask

   task automatic av_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
      bit ok = 0;
      @(posedge clk); #1;
      av_address = a; av_writedata = d; av_byteenable = be; av_write = 1'b1;
      for (int n = 0; n < 40 && !ok; n++) begin
         @(negedge clk); #1;
         ok = !av_waitrequest;
      end
      if (!ok) chk("av_write_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
      av_write = 1'b0;
   endtask

   task automatic av_rd_finish;
      bit ok = 0;
      for (int n = 0; n < 40 && !ok; n++) begin
         @(negedge clk); #1;
         ok = !av_waitrequest;
      end
      if (!ok) chk("av_read_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
      av_read = 1'b0;
   endtask

   task automatic do_reset;
      @(posedge clk); #1;
      reset = 1'b1; av_read = 1'b0; av_write = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      int bad;
      repeat (2) @(negedge clk);
      chk("reset_ram_we", 32'(ram_we), 32'd0);
      chk("reset_waitreq", 32'(av_waitrequest), 32'd1);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_monitor_ready", 32'(monitor_ready), 32'd1);
      chk("rst_overrun", 32'(jtag_overrun), 32'd0);
      chk("rst_MonDReg", MonDReg, 32'd0);
      chk("rst_readdata", av_readdata, 32'd0);
      chk("rst_jtag_addr", 32'(dut.jtag_addr), 32'd0);
      // JTAG write sequence with auto-increment
      jtag(0, 32'h10);
      jtag(1, 32'hDEADBEEF); wait_idle;
      jtag(1, 32'h12345678); wait_idle;
      chk("ram_10", ram[8'h10], 32'hDEADBEEF);
      chk("ram_11", ram[8'h11], 32'h12345678);
      chk("jtag_addr_12", 32'(dut.jtag_addr), 32'h12);
      // JTAG read latency
      av_wr(8'h20, 32'hA5A5A5A5, 4'hF);
      jtag(0, 32'h20);
      jtag(2, 32'h0);
      @(negedge clk); chk("rd_lat_c1", 32'(monitor_ready), 32'd0);
      @(negedge clk); chk("rd_lat_c2", 32'(monitor_ready), 32'd0);
      @(negedge clk); chk("rd_lat_ready", 32'(monitor_ready), 32'd1);
      chk("rd_lat_data", MonDReg, 32'hA5A5A5A5);
      // Contention: Avalon read held while JTAG reads repeat
      do_reset;
      av_wr(8'h05, 32'h55AA0005, 4'hF);
      av_wr(8'h30, 32'h30303030, 4'hF);
      av_wr(8'h31, 32'h31313131, 4'hF);
      av_wr(8'h32, 32'h32323232, 4'hF);
      jtag(0, 32'h30);
      glog = "";
      jdone = 1'b0;
      jtag(2, 32'h0);
      av_address = 8'h05; av_read = 1'b1;
      fork
         begin
            wait_idle; jtag(2, 32'h0);
            wait_idle; jtag(2, 32'h0);
            wait_idle; jdone = 1'b1;
         end
         begin
            bit ok = 0;
            for (int n = 0; n < 100 && !ok; n++) begin
               @(negedge clk); #1;
               ok = jdone && !av_waitrequest;
            end
            if (!ok) chk("contention_timeout", 32'd1, 32'd0);
            @(posedge clk); #1 av_read = 1'b0;
         end
      join
      n_chk++;
      if (glog != "JAJAJA") begin
         n_fail++;
         $display("FAIL grant_order: got %s expected JAJAJA", glog);
      end
      // Overrun: second write arrives while the first waits behind Avalon
      jtag(0, 32'h50);
      @(posedge clk); #1;
      av_address = 8'h05; av_read = 1'b1;
      take_action_ocimem_b = 1'b1; jdo = {3'b0, 32'h11111111, 3'b0};
      @(posedge clk); #1 jdo = {3'b0, 32'h22222222, 3'b0};
      @(posedge clk); #1 take_action_ocimem_b = 1'b0;
      av_rd_finish;
      wait_idle;
      chk("ovr_ram_50", ram[8'h50], 32'h11111111);
      chk("ovr_ram_51", ram[8'h51], 32'h0);
      chk("ovr_flag", 32'(jtag_overrun), 32'd1);
      jtag(0, 32'h60);
      @(negedge clk); chk("ovr_cleared", 32'(jtag_overrun), 32'd0);
      // Address wrap
      jtag(0, 32'hFF);
      jtag(1, 32'h0BADF00D); wait_idle;
      jtag(1, 32'hCAFEF00D); wait_idle;
      chk("wrap_ff", ram[8'hFF], 32'h0BADF00D);
      chk("wrap_00", ram[8'h00], 32'hCAFEF00D);
      // Byte enables
      av_wr(8'h40, 32'h11223344, 4'hF);
      av_wr(8'h40, 32'hAABBCCDD, 4'b0010);
      chk("byte_enable", ram[8'h40], 32'h1122CC44);
      // Reset in the return cycle of an Avalon read
      @(posedge clk); #1 av_address = 8'h07; av_read = 1'b1;
      @(posedge clk); #1 reset = 1'b1;
      #1 chk("midrst_wait_a", 32'(av_waitrequest), 32'd1);
      @(negedge clk);
      chk("midrst_wait_b", 32'(av_waitrequest), 32'd0 + 32'd1);
      chk("midrst_rdata", av_readdata, 32'd0);
      @(posedge clk); #1;
      chk("midrst_state", 32'(dut.state), 32'(IDLE));
      av_read = 1'b0; reset = 1'b0;
      @(negedge clk);
      chk("midrst_MonDReg", MonDReg, 32'd0);
      chk("midrst_ready", 32'(monitor_ready), 32'd1);
      bad = 0;
      for (int i = 0; i < 256; i++) if (ram[i] !== exp_mem[i]) bad++;
      chk("ram_image", 32'(bad), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, limit 300000 expected finish earlier");
      $fatal(1);
   end
endmodule
